// File: rtl/lsu_store_misalign_split_if.sv
// Store-request and dcache-write bundle for the misaligned store splitter.
// The slave modport is the splitter's view; master is the LSU/dcache side.
interface lsu_store_misalign_split_if;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        flush_i;
  logic        dc_valid_o;
  logic [31:0] dc_addr_o;
  logic [31:0] dc_wdata_o;
  logic [3:0]  dc_sel_o;
  logic        dc_ack_i;
  logic        stall_o;
  logic        misaligned_o;
  logic        done_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_size_i, flush_i, dc_ack_i,
    output dc_valid_o, dc_addr_o, dc_wdata_o, dc_sel_o, stall_o, misaligned_o, done_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_size_i, flush_i, dc_ack_i,
    input  dc_valid_o, dc_addr_o, dc_wdata_o, dc_sel_o, stall_o, misaligned_o, done_o
  );
endinterface

// File: rtl/lsu_store_misalign_split.sv
// Store splitter: turns a byte/half/word store at any byte address into one
// or two word-aligned dcache writes with byte enables, stalling upstream
// until the last beat is acknowledged.
module lsu_store_misalign_split (
  input  logic                        clk,
  input  logic                        reset,
  lsu_store_misalign_split_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [63:0] data_q;
  logic [7:0]  mask_q;
  logic        split_q;

  logic [1:0]  off;
  logic [3:0]  base_d;
  logic [7:0]  mask_d;
  logic [63:0] data_d;
  logic [31:0] addr_d;
  logic        split_d;

  // Lane-position the incoming store across a two-word window
  always_comb begin
    off = bus.req_addr_i[1:0];
    case (bus.req_size_i)
      2'b00:   base_d = 4'b0001;
      2'b01:   base_d = 4'b0011;
      default: base_d = 4'b1111;  // 11 is reserved and handled as a word
    endcase
    mask_d  = {4'b0000, base_d} << off;
    data_d  = {32'h0, bus.req_wdata_i} << {off, 3'b000};
    addr_d  = {bus.req_addr_i[31:2], 2'b00};
    split_d = |mask_d[7:4];
  end

  // State and captured store; an ack in LO beats a same-cycle flush, HI ignores flush
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      data_q  <= 64'h0;
      mask_q  <= 8'h0;
      split_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i && !bus.flush_i) begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            split_q <= split_d;
            state_q <= LO;
          end
        end
        LO: begin
          if (bus.dc_ack_i)    state_q <= split_q ? HI : IDLE;
          else if (bus.flush_i) state_q <= IDLE;
        end
        HI: begin
          if (bus.dc_ack_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat outputs decoded from state; bus fields forced to zero when not valid
  always_comb begin
    bus.dc_valid_o   = 1'b0;
    bus.dc_addr_o    = 32'h0;
    bus.dc_wdata_o   = 32'h0;
    bus.dc_sel_o     = 4'h0;
    bus.stall_o      = 1'b0;
    bus.misaligned_o = 1'b0;
    bus.done_o       = 1'b0;
    case (state_q)
      IDLE: begin
        // hold the requesting stage in the very cycle it presents the store
        bus.stall_o = bus.req_valid_i;
      end
      LO: begin
        bus.dc_valid_o   = 1'b1;
        bus.dc_addr_o    = addr_q;
        bus.dc_wdata_o   = data_q[31:0];
        bus.dc_sel_o     = mask_q[3:0];
        bus.stall_o      = 1'b1;
        bus.misaligned_o = split_q;
        bus.done_o       = bus.dc_ack_i && !split_q;
      end
      HI: begin
        bus.dc_valid_o   = 1'b1;
        bus.dc_addr_o    = addr_q + 32'd4;  // wraps past 0xFFFFFFFC
        bus.dc_wdata_o   = data_q[63:32];
        bus.dc_sel_o     = mask_q[7:4];
        bus.stall_o      = 1'b1;
        bus.misaligned_o = 1'b1;
        bus.done_o       = bus.dc_ack_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_store_misalign_split.sv
// Bench for the store splitter: directed cases from the store scenarios plus
// randomized stores checked against a byte-level reference model.
module tb_lsu_store_misalign_split;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   scnt;

  always #5 clk = ~clk;

  lsu_store_misalign_split_if bus ();

  lsu_store_misalign_split dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input bit st, input bit mi, input bit dn);
    chk({tag, ".valid"}, {31'h0, bus.dc_valid_o}, {31'h0, v});
    chk({tag, ".addr"},  bus.dc_addr_o, a);
    chk({tag, ".wdata"}, bus.dc_wdata_o, d);
    chk({tag, ".sel"},   {28'h0, bus.dc_sel_o}, {28'h0, s});
    chk({tag, ".stall"}, {31'h0, bus.stall_o}, {31'h0, st});
    chk({tag, ".mis"},   {31'h0, bus.misaligned_o}, {31'h0, mi});
    chk({tag, ".done"},  {31'h0, bus.done_o}, {31'h0, dn});
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One store transaction, starting in IDLE. Reference: place each store byte
  // at its absolute byte address, group by containing word.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input int wlo, input int whi,
                          input bit fl_wait, input bit fl_ack, input bit fl_hi,
                          output int stall_cycles);
    int          nb;
    int          lane;
    int          waits;
    int          beats;
    bit          split;
    bit          last;
    bit          abort;
    logic [63:0] d64;
    logic [7:0]  sel8;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [3:0]  esel;
    nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    d64  = 64'h0;
    sel8 = 8'h0;
    for (int k = 0; k < 4; k++) begin
      lane = int'(addr[1:0]) + k;
      d64[lane*8 +: 8] = data[k*8 +: 8];
      if (k < nb) sel8[lane] = 1'b1;
    end
    split = (sel8[7:4] != 4'h0);
    beats = split ? 2 : 1;
    stall_cycles = 0;

    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = data;
    bus.req_size_i  = size;
    bus.flush_i     = 1'b0;
    bus.dc_ack_i    = 1'b0;
    #2;
    chk_out("req", 0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    stall_cycles += int'(bus.stall_o);
    step();

    for (int b = 0; b < beats; b++) begin
      waits = (b == 0) ? wlo : whi;
      eaddr = (addr & 32'hFFFF_FFFC) + 32'(4 * b);
      edata = d64[b*32 +: 32];
      esel  = sel8[b*4 +: 4];
      for (int w = 0; w <= waits; w++) begin
        last  = (w == waits);
        abort = (b == 0) && fl_wait && (w == 0) && (waits > 0);
        // junk on the request side must be ignored outside IDLE
        bus.req_valid_i = 1'($urandom);
        bus.req_addr_i  = $urandom;
        bus.req_wdata_i = $urandom;
        bus.req_size_i  = 2'($urandom);
        bus.dc_ack_i    = last;
        bus.flush_i     = abort || ((b == 0) && last && fl_ack) || ((b == 1) && fl_hi);
        #2;
        chk_out((b == 0) ? "lo" : "hi", 1, eaddr, edata, esel, 1, split,
                last && (b == beats - 1));
        stall_cycles += int'(bus.stall_o);
        step();
        if (abort) begin
          bus.req_valid_i = 1'b0;
          bus.flush_i     = 1'b0;
          bus.dc_ack_i    = 1'b0;
          #2;
          chk_out("abort", 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
          step();
          return;
        end
      end
    end
    bus.req_valid_i = 1'b0;
    bus.dc_ack_i    = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    reset           = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.req_wdata_i = 32'h0;
    bus.req_size_i  = 2'b00;
    bus.flush_i     = 1'b0;
    bus.dc_ack_i    = 1'b0;
    step();
    step();
    #2;
    chk_out("reset", 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    reset = 1'b0;
    step();

    // directed scenarios
    do_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0, scnt);
    chk("stall_aligned", 32'(scnt), 32'd2);
    do_store(32'h0000_0103, 32'hAABB_CCDD, 2'b10, 0, 0, 0, 0, 0, scnt);
    chk("stall_split", 32'(scnt), 32'd3);
    do_store(32'h0000_0207, 32'h0000_1234, 2'b01, 0, 0, 0, 0, 0, scnt);
    do_store(32'h0000_0202, 32'h0000_1234, 2'b01, 0, 0, 0, 0, 0, scnt);
    do_store(32'hFFFF_FFFE, 32'h1122_3344, 2'b10, 3, 3, 0, 0, 0, scnt);
    chk("stall_wrap", 32'(scnt), 32'd9);
    do_store(32'h0000_0301, 32'h5566_7788, 2'b10, 2, 0, 1, 0, 0, scnt);   // flush in LO wait
    do_store(32'h0000_0302, 32'h5566_7788, 2'b10, 0, 2, 0, 1, 1, scnt);   // flush with LO ack, and in HI
    do_store(32'h0000_0305, 32'hCAFE_F00D, 2'b11, 1, 1, 0, 0, 0, scnt);   // reserved size

    // flush in IDLE drops the request
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0000_0400;
    bus.req_size_i  = 2'b10;
    bus.flush_i     = 1'b1;
    #2;
    chk("idle_flush.stall", {31'h0, bus.stall_o}, 32'd1);
    step();
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    #2;
    chk_out("idle_flush", 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    step();

    // reset while the second beat is outstanding
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0000_0503;
    bus.req_wdata_i = 32'h0102_0304;
    bus.req_size_i  = 2'b10;
    step();
    bus.req_valid_i = 1'b0;
    bus.dc_ack_i    = 1'b1;
    step();
    bus.dc_ack_i = 1'b0;
    #2;
    chk("rst_hi.addr_pre", bus.dc_addr_o, 32'h0000_0504);
    reset = 1'b1;
    step();
    #2;
    chk_out("rst_hi", 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    reset = 1'b0;
    step();
    #2;
    chk_out("rst_hi_after", 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    step();

    // randomized stores
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      do_store(ra, $urandom, 2'($urandom_range(0, 3)),
               $urandom_range(0, 2), $urandom_range(0, 2),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), scnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_store_misalign_split.md
Name: lsu_store_misalign_split

Overview:
- Write-side counterpart to the fetch realigner: sits between the LSU store path and the dcache write port.
- Accepts one byte, halfword or word store at any byte address.
- Issues one word-aligned write when the store fits inside one 32-bit word, or two word-aligned writes with byte enables when it straddles a word boundary.
- Holds the pipeline with stall_o until every beat is acknowledged.

Parameters:
- None. Address and data widths are fixed at 32 bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid_i  input  1  store request from the LSU; sampled only in IDLE
- req_addr_i  input  32  byte address, any alignment
- req_wdata_i  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- flush_i  input  1  pipeline flush (branch or trap)
- dc_valid_o  output  1  dcache write request valid
- dc_addr_o  output  32  word-aligned address, bits [1:0] always 00
- dc_wdata_o  output  32  write data, lane-positioned
- dc_sel_o  output  4  byte enables
- dc_ack_i  input  1  dcache accepted the current beat
- stall_o  output  1  freeze PC and upstream stages
- misaligned_o  output  1  the current operation is a split (two-beat) store
- done_o  output  1  one-cycle pulse on the ack of the final beat

Behaviour:
- Reset: state=IDLE; all outputs 0; internal address, data and mask registers cleared.
- Capture in IDLE when req_valid_i=1:
  - off=req_addr_i[1:0].
  - base mask: byte 0001, half 0011, word 1111.
  - mask8 = base<<off (8 bits).
  - data64 = zero-extended req_wdata_i << (8*off) (64 bits).
  - word_addr = {req_addr_i[31:2],2'b00}.
  - split = |mask8[7:4].
  - Register word_addr, data64, mask8 and split; next state LO.
- States:
  - IDLE:
    - dc_valid_o=0.
    - stall_o=req_valid_i, so the requesting stage is held in the cycle it presents the request.
  - LO:
    - dc_valid_o=1, dc_addr_o=word_addr, dc_wdata_o=data64[31:0], dc_sel_o=mask8[3:0].
    - stall_o=1, misaligned_o=split.
    - On dc_ack_i: if split go to HI; otherwise pulse done_o and go to IDLE.
    - No ack: hold, with outputs stable.
  - HI:
    - dc_valid_o=1, dc_addr_o=word_addr+4 (32-bit add, wraps modulo 2^32), dc_wdata_o=data64[63:32], dc_sel_o=mask8[7:4].
    - stall_o=1, misaligned_o=1.
    - On dc_ack_i: pulse done_o and go to IDLE.
- Latency with zero-wait ack:
  - Request accepted in cycle N, LO presented in cycle N+1.
  - Aligned store: done_o in N+1.
  - Split store: done_o in N+2.
  - stall_o is high from N through the done cycle.
  - Each wait cycle adds one cycle.
- Back-to-back: a new request is sampled only in IDLE, so there is one idle cycle between consecutive stores.
- Flush:
  - flush_i in LO with no ack in the same cycle: abort, go to IDLE, no done_o, nothing written.
  - flush_i with dc_ack_i in the same LO cycle: the ack wins, and a split store continues to HI.
  - flush_i in HI is ignored; the second beat must complete so no partial misaligned store is left.
  - flush_i in IDLE: any request in that cycle is dropped.
- Reset mid-operation returns to IDLE immediately; an outstanding beat is abandoned.
- dc_addr_o, dc_wdata_o and dc_sel_o are 0 whenever dc_valid_o=0.

Test Plan:
- Aligned word: addr 0x100, data 0xDEADBEEF, size 10, ack every cycle -> one beat: addr 0x100, sel 1111, wdata 0xDEADBEEF; done_o the next cycle; misaligned_o=0.
- Misaligned word: addr 0x103, data 0xAABBCCDD, size 10 ->
  - beat 1: addr 0x100, sel 1000, wdata 0xDD000000;
  - beat 2: addr 0x104, sel 0111, wdata 0x00AABBCC;
  - misaligned_o=1 in both beats; done_o on the second ack.
- Half crossing: addr 0x207, data 0x1234, size 01 ->
  - beat 1: 0x204, sel 1000, wdata 0x34000000;
  - beat 2: 0x208, sel 0001, wdata 0x00000012.
- Non-crossing half: addr 0x202 -> single beat at 0x200, sel 1100, wdata 0x12340000.
- Wait states and wrap-around: misaligned word at 0xFFFFFFFE with dc_ack_i held low 3 cycles per beat ->
  - outputs stable while waiting;
  - beat 2 addr 0x00000000, sel 0011;
  - stall_o high for 9 cycles total.
- Flush behaviour:
  - flush_i in LO with no ack -> IDLE, no done_o, no further dc_valid_o.
  - flush_i in HI -> the HI beat still completes and done_o pulses.
  - reset asserted in HI -> all outputs 0 on the next cycle.
